avm_dma_wbiu: RTL and testbench
===============================

AVM_DMA_WBIU -- requirements
Module: avm_dma_wbiu

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning Avalon address width in bits.
REQ-002 The block SHALL have parameter AL, default 2, meaning log2 of bytes per data word.
REQ-003 The block SHALL have parameter BL, default 3, meaning log2 of the maximum burst length in beats.
REQ-004 The block SHALL have parameter DW, default 8*(2**AL), meaning data width in bits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port bus_wval, input, 1 bit: burst command valid.
REQ-008 The block SHALL have port bus_wrdy, output, 1 bit: burst command ready.
REQ-009 The block SHALL have port bus_wlen, input, BL+1 bits: burst length in beats; legal range 1..2**BL.
REQ-010 The block SHALL have port bus_waddr, input, AW bits: burst byte address.
REQ-011 The block SHALL have port bus_wdata, input, DW bits: head-of-FIFO write data.
REQ-012 The block SHALL have port bus_wack, output, 1 bit: pulse that pops one word from the upstream FIFO.
REQ-013 The block SHALL have port bus_abort, input, 1 bit: request to flush the current burst.
REQ-014 The block SHALL have port avm_address, output, AW bits: Avalon-MM address.
REQ-015 The block SHALL have port avm_burstcount, output, BL+1 bits: Avalon-MM burst count.
REQ-016 The block SHALL have port avm_write, output, 1 bit: Avalon-MM write strobe.
REQ-017 The block SHALL have port avm_writedata, output, DW bits: Avalon-MM write data.
REQ-018 The block SHALL have port avm_byteenable, output, DW/8 bits: Avalon-MM byte enables.
REQ-019 The block SHALL have port avm_waitrequest, input, 1 bit: Avalon-MM stall.
REQ-020 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-021 The block SHALL have port err, output, 2 bits: sticky flags; [0] = illegal length, [1] = aborted burst.

Function
REQ-022 The block SHALL implement the state machine IDLE -> BURST -> IDLE, plus FLUSH (BURST -> FLUSH -> IDLE).
REQ-023 bus_wrdy SHALL be 1 only in IDLE with rst_n high; a command is accepted when bus_wval & bus_wrdy.
REQ-024 On acceptance of a legal length, the block SHALL latch {bus_waddr[AW-1:AL], AL'b0} into avm_address and bus_wlen into avm_burstcount, set beat counter = bus_wlen, and enter BURST next cycle.
REQ-025 On acceptance of a length that is 0 or greater than 2**BL, the block SHALL drop the command, set err[0], stay in IDLE, and issue no bus_wack.
REQ-026 In BURST and FLUSH, avm_write SHALL be 1, with avm_address and avm_burstcount held constant for the whole burst.
REQ-027 A beat SHALL complete when avm_write & ~avm_waitrequest; the beat counter decrements by 1 per completed beat.
REQ-028 In BURST, avm_writedata SHALL equal bus_wdata and avm_byteenable SHALL be all ones; bus_wack SHALL equal the beat-complete pulse in the same cycle.
REQ-029 When the last beat completes (counter == 1 at completion), the state SHALL return to IDLE next cycle, with avm_write 0 in that cycle.
REQ-030 There SHALL be at least one idle cycle between bursts (bus_wrdy is not asserted in the last-beat cycle).
REQ-031 If bus_abort is 1 in BURST, the block SHALL enter FLUSH next cycle and set err[1]; a beat completing in the abort cycle is treated as a normal beat.
REQ-032 In FLUSH, the block SHALL drive remaining beats with avm_writedata = 0 and avm_byteenable = 0, with bus_wack held 0, until the counter reaches 0, then go to IDLE.
REQ-033 bus_abort SHALL be ignored in IDLE and in FLUSH.
REQ-034 While avm_waitrequest = 1, all avm_* outputs SHALL hold unchanged.
REQ-035 bus_wack SHALL never be asserted outside BURST.
REQ-036 err bits SHALL be cleared only by reset.

Reset
REQ-037 While rst_n = 0 at a clock edge, the block SHALL set: state IDLE, beat counter 0, avm_write 0, avm_address 0, avm_burstcount 0, avm_writedata 0, avm_byteenable 0, bus_wack 0, bus_wrdy 0, busy 0, err 0.
REQ-038 Reset asserted mid-burst SHALL end the burst immediately; the Avalon slave is reset by the same domain, so no flush is performed.
REQ-039 bus_wrdy SHALL return to 1 in the first cycle with rst_n high.

Verification
REQ-040 Scenario: bus_wlen = 4, bus_waddr = 0x1003, avm_waitrequest = 0 -> 4 consecutive beats, avm_address = 0x1000, avm_burstcount = 4, 4 bus_wack pulses, then IDLE.
REQ-041 Scenario: bus_wlen = 8, avm_waitrequest high for 3 cycles on beat 2 -> all avm_* outputs stable for those 3 cycles, exactly 8 bus_wack pulses in total.
REQ-042 Scenario: bus_wlen = 0, then bus_wlen = 9 -> no avm_write, no bus_wack, err = 2'b01.
REQ-043 Scenario: bus_wlen = 8, bus_abort asserted after beat 3 -> 3 bus_wack pulses, 5 beats with byteenable = 0, err[1] = 1.
REQ-044 Scenario: two back-to-back commands of length 2 -> exactly one idle cycle between them; the second avm_address is latched correctly.
REQ-045 Scenario: rst_n pulled low during beat 2 of 4 -> next cycle all outputs take their reset values; a new command is accepted after release.

Source files
------------

// File: rtl/avm_dma_wbiu_if.sv
// Signal bundle between the upstream burst-command/FIFO port and the Avalon-MM write master.
// The "slave" modport is the bridge's view; "master" is the view of whatever drives it.
interface avm_dma_wbiu_if #(
  parameter int AW = 32,
  parameter int AL = 2,
  parameter int BL = 3,
  parameter int DW = 8 * (2 ** AL)
);
  // Upstream command and FIFO side
  logic            bus_wval;
  logic            bus_wrdy;
  logic [BL:0]     bus_wlen;
  logic [AW-1:0]   bus_waddr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_wack;
  logic            bus_abort;

  // Avalon-MM write master side
  logic [AW-1:0]   avm_address;
  logic [BL:0]     avm_burstcount;
  logic            avm_write;
  logic [DW-1:0]   avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;

  modport slave (
    input  bus_wval, bus_wlen, bus_waddr, bus_wdata, bus_abort, avm_waitrequest,
    output bus_wrdy, bus_wack, avm_address, avm_burstcount, avm_write,
           avm_writedata, avm_byteenable
  );

  modport master (
    output bus_wval, bus_wlen, bus_waddr, bus_wdata, bus_abort, avm_waitrequest,
    input  bus_wrdy, bus_wack, avm_address, avm_burstcount, avm_write,
           avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/avm_dma_wbiu.sv
// DMA write-burst bridge: turns a burst command plus an upstream FIFO into one Avalon-MM
// write burst, with an abort path that pads the remaining beats with byte-masked writes.
module avm_dma_wbiu #(
  parameter int AW = 32,
  parameter int AL = 2,
  parameter int BL = 3,
  parameter int DW = 8 * (2 ** AL)
) (
  input  logic         clk,
  input  logic         rst_n,
  avm_dma_wbiu_if.slave bif,
  output logic         busy,
  output logic [1:0]   err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [BL:0] MAX_LEN = {1'b1, {BL{1'b0}}};
  localparam logic [BL:0] LEN_ONE = {{BL{1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [BL:0]   cnt_q,   cnt_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [BL:0]   bcnt_q,  bcnt_d;
  logic [1:0]    err_q,   err_d;

  logic          avm_write;
  logic          beat_done;
  logic          cmd_take;
  logic          len_ok;
  logic          last_beat;

  // Sub-word address bits are dropped on purpose: bursts are always word aligned.
  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^bif.bus_waddr[AL-1:0];

  assign avm_write = (state_q != IDLE);
  assign beat_done = avm_write & ~bif.avm_waitrequest;
  assign cmd_take  = bif.bus_wval & bif.bus_wrdy;
  assign len_ok    = (bif.bus_wlen != '0) && (bif.bus_wlen <= MAX_LEN);
  assign last_beat = beat_done && (cnt_q == LEN_ONE);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_take) begin
          if (len_ok) begin
            state_d = BURST;
            cnt_d   = bif.bus_wlen;
            bcnt_d  = bif.bus_wlen;
            addr_d  = {bif.bus_waddr[AW-1:AL], {AL{1'b0}}};
          end else begin
            err_d[0] = 1'b1;
          end
        end
      end

      BURST: begin
        if (beat_done) cnt_d = cnt_q - 1'b1;
        if (bif.bus_abort) err_d[1] = 1'b1;
        // A beat finishing the burst wins over a simultaneous abort: nothing is left to flush.
        if (last_beat) begin
          state_d = IDLE;
        end else if (bif.bus_abort) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (beat_done) cnt_d = cnt_q - 1'b1;
        if (last_beat || cnt_q == '0) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  // Data path is combinational from the FIFO head, so it holds naturally while stalled.
  assign bif.bus_wrdy       = rst_n & (state_q == IDLE);
  assign bif.bus_wack       = (state_q == BURST) & beat_done;
  assign bif.avm_write      = avm_write;
  assign bif.avm_address    = addr_q;
  assign bif.avm_burstcount = bcnt_q;
  assign bif.avm_writedata  = (state_q == BURST) ? bif.bus_wdata : '0;
  assign bif.avm_byteenable = (state_q == BURST) ? '1 : '0;

  assign busy = avm_write;
  assign err  = err_q;

endmodule

// File: tb/tb_avm_dma_wbiu.sv
// Directed bench for avm_dma_wbiu: normal bursts, stalls, illegal lengths, abort/flush,
// back-to-back commands and reset in the middle of a burst.
module tb_avm_dma_wbiu;
  localparam int AW = 32;
  localparam int AL = 2;
  localparam int BL = 3;
  localparam int DW = 8 * (2 ** AL);
  localparam int SW = AW + (BL + 1) + 1 + DW + DW / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] err;

  int n_tests = 0;
  int n_fail  = 0;
  int fifo_idx = 0;

  avm_dma_wbiu_if #(.AW(AW), .AL(AL), .BL(BL)) bif ();

  avm_dma_wbiu #(.AW(AW), .AL(AL), .BL(BL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bif  (bif),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One burst: accept cycle (must be idle), then beats until the model has counted len.
  task automatic do_burst(input int len, input logic [AW-1:0] addr, input int stall_beat,
                          input int stall_cycles, input int abort_after,
                          output int wacks, output int zbeats, output int cycles);
    int beats, stall_left;
    bit flush, aborted, stall_now, do_abort, stalled;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [SW-1:0] snap, now_v;
    exp_addr = {addr[AW-1:AL], {AL{1'b0}}};
    beats = 0; wacks = 0; zbeats = 0; cycles = 0;
    stall_left = stall_cycles; flush = 0; aborted = 0; snap = '0;

    @(negedge clk);
    bif.bus_wval = 1'b1; bif.bus_wlen = len[BL:0]; bif.bus_waddr = addr;
    bif.bus_wdata = 32'hD000_0000 + fifo_idx; bif.avm_waitrequest = 1'b0; bif.bus_abort = 1'b0;
    #2;
    n_tests++;
    if (bif.bus_wrdy !== 1'b1 || busy !== 1'b0 || bif.avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_idle: wrdy=%b busy=%b write=%b, required 1/0/0",
               bif.bus_wrdy, busy, bif.avm_write);
    end

    for (int c = 0; c < 64 && beats < len; c++) begin
      @(negedge clk);
      bif.bus_wval = 1'b0;
      exp_wd = 32'hD000_0000 + fifo_idx;
      bif.bus_wdata = exp_wd;
      do_abort  = !aborted && abort_after > 0 && beats == abort_after;
      stall_now = stall_left > 0 && beats == stall_beat - 1;
      stalled   = stall_now || do_abort;
      bif.avm_waitrequest = stalled;
      bif.bus_abort = do_abort;
      #2;
      cycles++;
      n_tests++;
      if (bif.avm_write !== 1'b1 || busy !== 1'b1 || bif.bus_wrdy !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_ctrl: write=%b busy=%b wrdy=%b, required 1/1/0",
                 bif.avm_write, busy, bif.bus_wrdy);
      end
      n_tests++;
      if (bif.avm_address !== exp_addr || bif.avm_burstcount !== len[BL:0]) begin
        n_fail++;
        $display("FAIL burst_hdr: addr=%h bc=%0d, required %h/%0d",
                 bif.avm_address, bif.avm_burstcount, exp_addr, len);
      end
      n_tests++;
      if (!flush) begin
        if (bif.avm_writedata !== exp_wd || bif.avm_byteenable !== 4'hF ||
            bif.bus_wack !== !stalled) begin
          n_fail++;
          $display("FAIL burst_data: wd=%h be=%h wack=%b, required %h/f/%b",
                   bif.avm_writedata, bif.avm_byteenable, bif.bus_wack, exp_wd, !stalled);
        end
      end else begin
        if (bif.avm_writedata !== '0 || bif.avm_byteenable !== '0 || bif.bus_wack !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_data: wd=%h be=%h wack=%b, required 0/0/0",
                   bif.avm_writedata, bif.avm_byteenable, bif.bus_wack);
        end
      end
      now_v = {bif.avm_address, bif.avm_burstcount, bif.avm_write,
               bif.avm_writedata, bif.avm_byteenable};
      if (stall_now) begin
        if (stall_left == stall_cycles) begin
          snap = now_v;
        end else begin
          n_tests++;
          if (now_v !== snap) begin
            n_fail++;
            $display("FAIL stall_hold: avm outputs %h, required %h", now_v, snap);
          end
        end
        stall_left--;
      end
      if (bif.bus_wack === 1'b1) begin
        wacks++;
        fifo_idx++;
      end
      if (!stalled) begin
        beats++;
        if (flush) zbeats++;
      end
      if (do_abort) begin
        aborted = 1;
        flush = 1;
      end
    end
    bif.bus_abort = 1'b0;
    bif.avm_waitrequest = 1'b0;
    n_tests++;
    if (beats != len) begin
      n_fail++;
      $display("FAIL burst_timeout: beats=%0d, required %0d", beats, len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.bus_wval = 1'b0; bif.bus_wlen = '0; bif.bus_waddr = '0; bif.bus_wdata = '0;
    bif.bus_abort = 1'b0; bif.avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_tests++;
    if (bif.avm_write !== 1'b0 || bif.avm_address !== '0 || bif.avm_burstcount !== '0 ||
        bif.avm_writedata !== '0 || bif.avm_byteenable !== '0) begin
      n_fail++;
      $display("FAIL reset_avm: write=%b addr=%h bc=%h wd=%h be=%h, required all 0",
               bif.avm_write, bif.avm_address, bif.avm_burstcount,
               bif.avm_writedata, bif.avm_byteenable);
    end
    n_tests++;
    if (bif.bus_wack !== 1'b0 || bif.bus_wrdy !== 1'b0 || busy !== 1'b0 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: wack=%b wrdy=%b busy=%b err=%b, required 0/0/0/00",
               bif.bus_wack, bif.bus_wrdy, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_tests++;
    if (bif.bus_wrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_wrdy: got %b, required 1", bif.bus_wrdy);
    end
  endtask

  task automatic test_basic();
    int wacks, zb, cyc;
    do_burst(4, 32'h0000_1003, 0, 0, 0, wacks, zb, cyc);
    n_tests++;
    if (wacks != 4 || zb != 0 || cyc != 4) begin
      n_fail++;
      $display("FAIL basic_counts: wack=%0d zero_be=%0d cycles=%0d, required 4/0/4", wacks, zb, cyc);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b0 || bif.avm_write !== 1'b0 || bif.bus_wrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b write=%b wrdy=%b, required 0/0/1",
               busy, bif.avm_write, bif.bus_wrdy);
    end
  endtask

  task automatic test_stall();
    int wacks, zb, cyc;
    do_burst(8, 32'h0000_2000, 2, 3, 0, wacks, zb, cyc);
    n_tests++;
    if (wacks != 8 || cyc != 11) begin
      n_fail++;
      $display("FAIL stall_counts: wack=%0d cycles=%0d, required 8/11", wacks, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int wacks, zb, cyc;
    do_burst(2, 32'h0000_3008, 0, 0, 0, wacks, zb, cyc);
    n_tests++;
    if (wacks != 2) begin
      n_fail++;
      $display("FAIL b2b_first_wack: got %0d, required 2", wacks);
    end
    do_burst(2, 32'h0000_40F6, 0, 0, 0, wacks, zb, cyc);
    n_tests++;
    if (wacks != 2 || cyc != 2) begin
      n_fail++;
      $display("FAIL b2b_second: wack=%0d cycles=%0d, required 2/2", wacks, cyc);
    end
  endtask

  task automatic test_illegal_len();
    int lens[2] = '{0, 9};
    foreach (lens[k]) begin
      @(negedge clk);
      bif.bus_wval = 1'b1; bif.bus_wlen = lens[k][BL:0]; bif.bus_waddr = 32'h0000_5000;
      #2;
      n_tests++;
      if (bif.bus_wrdy !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_wrdy: got %b, required 1", bif.bus_wrdy);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        bif.bus_wval = 1'b0;
        #2;
        n_tests++;
        if (bif.avm_write !== 1'b0 || bif.bus_wack !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL illegal_quiet: write=%b wack=%b busy=%b, required 0/0/0",
                   bif.avm_write, bif.bus_wack, busy);
        end
      end
    end
    n_tests++;
    if (err !== 2'b01) begin
      n_fail++;
      $display("FAIL illegal_err: got %b, required 01", err);
    end
  endtask

  task automatic test_abort();
    int wacks, zb, cyc;
    do_burst(8, 32'h0000_6000, 0, 0, 3, wacks, zb, cyc);
    n_tests++;
    if (wacks != 3 || zb != 5) begin
      n_fail++;
      $display("FAIL abort_counts: wack=%0d zero_be=%0d, required 3/5", wacks, zb);
    end
    n_tests++;
    if (err !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_err: got %b, required 11", err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int wacks, zb, cyc;
    @(negedge clk);
    bif.bus_wval = 1'b1; bif.bus_wlen = 4'd4; bif.bus_waddr = 32'h0000_7000;
    bif.avm_waitrequest = 1'b0;
    @(negedge clk);
    bif.bus_wval = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b, required 1", busy);
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (bif.avm_write !== 1'b0 || bif.avm_address !== '0 || bif.avm_burstcount !== '0 ||
        bif.avm_writedata !== '0 || bif.avm_byteenable !== '0 || bif.bus_wack !== 1'b0 ||
        bif.bus_wrdy !== 1'b0 || busy !== 1'b0 || err !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_outputs: write=%b addr=%h bc=%h wd=%h be=%h wack=%b wrdy=%b busy=%b err=%b, required all 0",
               bif.avm_write, bif.avm_address, bif.avm_burstcount, bif.avm_writedata,
               bif.avm_byteenable, bif.bus_wack, bif.bus_wrdy, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_tests++;
    if (bif.bus_wrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_wrdy: got %b, required 1", bif.bus_wrdy);
    end
    do_burst(1, 32'h0000_8004, 0, 0, 0, wacks, zb, cyc);
    n_tests++;
    if (wacks != 1) begin
      n_fail++;
      $display("FAIL midrst_new_cmd: wack=%0d, required 1", wacks);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_illegal_len();
    test_abort();
    test_reset_mid_burst();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
